bp_be_thread_scheduler: RTL and testbench

- Time-slice and event-driven scheduler for hardware threads sharing one BE pipeline.
- Decides when to context switch and which thread runs next.
- Holds the saved NPC of every descheduled thread and presents the incoming thread's NPC as the context NPC consumed by the director on a commit-stage ctxtsw.
- Sits beside the director and the commit stage; the commit stage accepts a switch request and asserts ctxtsw for exactly one cycle.

---
 rtl/bp_be_thread_scheduler.sv | 129 ++++++++++++
 tb/tb_bp_be_thread_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_thread_scheduler.sv
// Round-robin hardware-thread scheduler: picks when to context switch (time slice or block event),
// which thread runs next, and keeps every descheduled thread's saved NPC for the director.
module bp_be_thread_scheduler #(
    parameter int num_threads_p   = 4,
    parameter int vaddr_width_p   = 39,
    parameter int quantum_width_p = 16,
    parameter logic [vaddr_width_p-1:0] boot_npc_p = 39'h0080000000,
    localparam int tid_width_lp   = (num_threads_p > 1) ? $clog2(num_threads_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       en_i,
    input  logic [quantum_width_p-1:0] quantum_i,
    input  logic [num_threads_p-1:0]   thread_ready_i,
    input  logic                       block_i,
    input  logic [vaddr_width_p-1:0]   cur_npc_i,
    output logic                       ctxtsw_req_o,
    input  logic                       ctxtsw_yumi_i,
    output logic [vaddr_width_p-1:0]   context_npc_o,
    output logic [tid_width_lp-1:0]    thread_id_o,
    output logic [tid_width_lp-1:0]    next_thread_id_o,
    input  logic                       npc_w_v_i,
    input  logic [tid_width_lp-1:0]    npc_w_tid_i,
    input  logic [vaddr_width_p-1:0]   npc_w_data_i
);

    typedef enum logic [1:0] {e_run, e_req, e_settle} state_e;

    state_e                     state_q, state_d;
    logic [tid_width_lp-1:0]    cur_q, cur_d, next_q, next_d;
    logic [quantum_width_p-1:0] counter_q, counter_d;
    logic [vaddr_width_p-1:0]   saved_npc_q [num_threads_p];
    logic [vaddr_width_p-1:0]   saved_npc_d [num_threads_p];

    logic                    cand_v;
    logic [tid_width_lp-1:0] cand_id;
    logic [tid_width_lp-1:0] scan_id;
    logic                    quantum_hit;
    logic                    trigger;
    logic                    sw_write;

    // Scan offsets from farthest to nearest so the nearest ready thread after cur_q wins.
    always_comb begin
        cand_v  = 1'b0;
        cand_id = '0;
        scan_id = '0;
        for (int i = num_threads_p - 1; i >= 1; i--) begin
            scan_id = tid_width_lp'((int'(cur_q) + i) % num_threads_p);
            if (thread_ready_i[scan_id]) begin
                cand_v  = 1'b1;
                cand_id = scan_id;
            end
        end
    end

    assign quantum_hit = (quantum_i != '0) && (counter_q >= quantum_i - 1'b1);
    assign trigger     = en_i && (block_i || quantum_hit);
    // The running thread's entry is stale, so software writes to it are dropped.
    assign sw_write    = npc_w_v_i && (npc_w_tid_i != cur_q)
                         && (int'(npc_w_tid_i) < num_threads_p);

    // NOTE: every variable gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        next_d      = next_q;
        counter_d   = counter_q;
        saved_npc_d = saved_npc_q;

        if (sw_write) begin
            saved_npc_d[npc_w_tid_i] = npc_w_data_i;
        end

        case (state_q)
            e_run: begin
                if ((quantum_i != '0) && (counter_q != '1)) begin
                    counter_d = counter_q + 1'b1;
                end
                if (trigger) begin
                    if (cand_v) begin
                        next_d  = cand_id;
                        state_d = e_req;
                    end else begin
                        counter_d = '0;
                    end
                end
            end
            e_req: begin
                if (ctxtsw_yumi_i) begin
                    saved_npc_d[cur_q] = cur_npc_i;
                    cur_d              = next_q;
                    counter_d          = '0;
                    state_d            = e_settle;
                end
            end
            e_settle: begin
                counter_d = '0;
                state_d   = e_run;
            end
            default: state_d = e_run;
        endcase
    end

    // NOTE: the NPC array is reset too, because every thread must boot from boot_npc_p.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= e_run;
            cur_q     <= '0;
            next_q    <= '0;
            counter_q <= '0;
            for (int i = 0; i < num_threads_p; i++) begin
                saved_npc_q[i] <= boot_npc_p;
            end
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            next_q      <= next_d;
            counter_q   <= counter_d;
            saved_npc_q <= saved_npc_d;
        end
    end

    assign ctxtsw_req_o     = (state_q == e_req);
    assign thread_id_o      = cur_q;
    assign next_thread_id_o = next_q;
    assign context_npc_o    = (sw_write && (npc_w_tid_i == next_q)) ? npc_w_data_i
                                                                     : saved_npc_q[next_q];

endmodule

// File: tb/tb_bp_be_thread_scheduler.sv
// Self-checking bench for bp_be_thread_scheduler: reset/table vectors, directed corner
// sequences, and a randomized run against a behavioural scheduler model.
module tb_bp_be_thread_scheduler;

    localparam int NT = 4;
    localparam int VW = 39;
    localparam int QW = 16;
    localparam logic [VW-1:0] BOOT = 39'h0080000000;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic          en_i;
    logic [QW-1:0] quantum_i;
    logic [NT-1:0] thread_ready_i;
    logic          block_i;
    logic [VW-1:0] cur_npc_i;
    logic          ctxtsw_req_o;
    logic          ctxtsw_yumi_i;
    logic [VW-1:0] context_npc_o;
    logic [1:0]    thread_id_o;
    logic [1:0]    next_thread_id_o;
    logic          npc_w_v_i;
    logic [1:0]    npc_w_tid_i;
    logic [VW-1:0] npc_w_data_i;

    bp_be_thread_scheduler dut (
        .clk_i            (clk),
        .reset_ni         (reset_ni),
        .en_i             (en_i),
        .quantum_i        (quantum_i),
        .thread_ready_i   (thread_ready_i),
        .block_i          (block_i),
        .cur_npc_i        (cur_npc_i),
        .ctxtsw_req_o     (ctxtsw_req_o),
        .ctxtsw_yumi_i    (ctxtsw_yumi_i),
        .context_npc_o    (context_npc_o),
        .thread_id_o      (thread_id_o),
        .next_thread_id_o (next_thread_id_o),
        .npc_w_v_i        (npc_w_v_i),
        .npc_w_tid_i      (npc_w_tid_i),
        .npc_w_data_i     (npc_w_data_i)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = running, 1 = requesting, 2 = one-cycle settle after a switch
    int          m_mode, m_cur, m_nxt, m_cnt;
    logic [VW-1:0] m_npc [NT];

    task automatic model_reset();
        m_mode = 0; m_cur = 0; m_nxt = 0; m_cnt = 0;
        for (int i = 0; i < NT; i++) m_npc[i] = BOOT;
    endtask

    function automatic logic [VW-1:0] model_ctx();
        if (npc_w_v_i && int'(npc_w_tid_i) == m_nxt && m_nxt != m_cur) return npc_w_data_i;
        return m_npc[m_nxt];
    endfunction

    task automatic model_step();
        int  old_cur = m_cur;
        int  q = int'(quantum_i);
        int  found = -1;
        bit  trig;
        if (npc_w_v_i && int'(npc_w_tid_i) != old_cur) m_npc[npc_w_tid_i] = npc_w_data_i;
        case (m_mode)
            0: begin
                trig = en_i && (block_i || (q != 0 && m_cnt >= q - 1));
                if (q != 0 && m_cnt < 65535) m_cnt++;
                if (trig) begin
                    for (int off = 1; off < NT; off++)
                        if (found < 0 && thread_ready_i[(old_cur + off) % NT]) found = (old_cur + off) % NT;
                    if (found >= 0) begin m_nxt = found; m_mode = 1; end
                    else m_cnt = 0;
                end
            end
            1: if (ctxtsw_yumi_i) begin
                m_npc[old_cur] = cur_npc_i;
                m_cur = m_nxt; m_cnt = 0; m_mode = 2;
            end
            default: begin m_mode = 0; m_cnt = 0; end
        endcase
    endtask

    // One clock: optionally compare outputs to the model, then advance DUT and model.
    task automatic tick(input bit chk = 1'b0);
        #1;
        if (chk) begin
            check("rnd_req",  ctxtsw_req_o,     m_mode == 1);
            check("rnd_tid",  thread_id_o,      m_cur);
            check("rnd_next", next_thread_id_o, m_nxt);
            check("rnd_ctx",  context_npc_o,    model_ctx());
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_in(input logic en, input logic [QW-1:0] q, input logic [NT-1:0] rdy,
                          input logic blk, input logic yumi);
        en_i = en; quantum_i = q; thread_ready_i = rdy; block_i = blk; ctxtsw_yumi_i = yumi;
    endtask

    task automatic apply_reset();
        reset_ni = 1'b0;
        model_reset();
        npc_w_v_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!ctxtsw_req_o && n < 50) begin tick(); n++; end
        check(name, ctxtsw_req_o, 1'b1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NT-1:0] rdy;
        logic          blk;
        logic          yumi;
        logic          exp_req;
        int            exp_tid;
        int            exp_nxt;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic [NT-1:0] r, input logic b, input logic y,
                                input logic er, input int et, input int en);
        vec_t v;
        v.rdy = r; v.blk = b; v.yumi = y; v.exp_req = er; v.exp_tid = et; v.exp_nxt = en;
        return v;
    endfunction

    initial begin
        int n;
        logic [VW-1:0] rnd;

        // en=1, quantum=3 throughout; expected outputs are those seen during each cycle.
        tbl[0]  = mk(4'hF, 0, 0, 0, 0, 0);
        tbl[1]  = mk(4'hF, 0, 0, 0, 0, 0);
        tbl[2]  = mk(4'hF, 0, 0, 0, 0, 0);   // counter reaches 2 -> request
        tbl[3]  = mk(4'hF, 0, 0, 1, 0, 1);
        tbl[4]  = mk(4'hF, 0, 1, 1, 0, 1);   // yumi
        tbl[5]  = mk(4'hF, 1, 0, 0, 1, 1);   // settle: block ignored
        tbl[6]  = mk(4'h9, 1, 0, 0, 1, 1);   // block, thread 2 not ready -> 3
        tbl[7]  = mk(4'h9, 0, 1, 1, 1, 3);
        tbl[8]  = mk(4'h8, 0, 0, 0, 3, 3);
        tbl[9]  = mk(4'h8, 0, 1, 0, 3, 3);   // stray yumi in run is ignored
        tbl[10] = mk(4'h8, 0, 0, 0, 3, 3);
        tbl[11] = mk(4'h8, 0, 0, 0, 3, 3);   // expiry, no candidate -> restart
        tbl[12] = mk(4'hF, 0, 0, 0, 3, 3);
        tbl[13] = mk(4'hF, 0, 0, 0, 3, 3);
        tbl[14] = mk(4'hF, 0, 0, 0, 3, 3);   // expiry again -> request thread 0
        tbl[15] = mk(4'hF, 0, 0, 1, 3, 0);

        cur_npc_i = 39'h0012345678; npc_w_tid_i = '0; npc_w_data_i = '0;
        set_in(1, 16'd3, 4'hF, 0, 0);
        apply_reset();
        #1;
        check("rst_req",  ctxtsw_req_o,     1'b0);
        check("rst_tid",  thread_id_o,      0);
        check("rst_next", next_thread_id_o, 0);
        check("rst_ctx",  context_npc_o,    BOOT);
        for (int i = 0; i < 16; i++) begin
            set_in(1, 16'd3, tbl[i].rdy, tbl[i].blk, tbl[i].yumi);
            #1;
            check($sformatf("tbl%0d_req", i),  ctxtsw_req_o,     tbl[i].exp_req);
            check($sformatf("tbl%0d_tid", i),  thread_id_o,      tbl[i].exp_tid);
            check($sformatf("tbl%0d_next", i), next_thread_id_o, tbl[i].exp_nxt);
            tick();
        end

        // Time-slice latency of 8 cycles after reset release.
        set_in(1, 16'd8, 4'hF, 0, 0);
        apply_reset();
        n = 0;
        while (!ctxtsw_req_o && n < 50) begin tick(); n++; end
        check("t1_latency", n, 8);
        check("t1_next", next_thread_id_o, 1);
        check("t1_ctx",  context_npc_o,    BOOT);

        // Switch to thread 1 saving 0x80001234, then rotate back to thread 0.
        cur_npc_i = 39'h0080001234;
        ctxtsw_yumi_i = 1'b1;
        tick();
        ctxtsw_yumi_i = 1'b0;
        check("t2_tid", thread_id_o, 1);
        set_in(1, 16'd0, 4'b0011, 1, 0);
        tick(); tick();
        check("t2_req",  ctxtsw_req_o,     1'b1);
        check("t2_next", next_thread_id_o, 0);
        check("t2_ctx",  context_npc_o,    39'h0080001234);

        // Request held while disabled and target not ready.
        set_in(0, 16'd0, 4'b0010, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5_hold_req",  ctxtsw_req_o,     1'b1);
            check("t5_hold_next", next_thread_id_o, 0);
        end

        // Yumi plus write to the incoming thread: bypassed this cycle.
        cur_npc_i = 39'h0080005555;
        ctxtsw_yumi_i = 1'b1;
        npc_w_v_i = 1'b1; npc_w_tid_i = 2'd0; npc_w_data_i = 39'h0080004000;
        #1;
        check("t6_bypass", context_npc_o, 39'h0080004000);
        tick();
        ctxtsw_yumi_i = 1'b0;
        npc_w_v_i = 1'b0;
        check("t6_tid", thread_id_o, 0);
        check("t6_stored", context_npc_o, 39'h0080004000);
        // Write to the running thread is dropped.
        npc_w_v_i = 1'b1; npc_w_tid_i = 2'd0; npc_w_data_i = 39'h0000000bad;
        #1;
        check("t6_cur_wr_now", context_npc_o, 39'h0080004000);
        tick();
        npc_w_v_i = 1'b0;
        #1;
        check("t6_cur_wr_after", context_npc_o, 39'h0080004000);

        // Mid-request asynchronous reset.
        set_in(1, 16'd0, 4'hF, 1, 0);
        wait_req("t5_req_timeout");
        check("t5_next_pre", next_thread_id_o, 1);
        check("t5_ctx_pre",  context_npc_o,    39'h0080005555);
        #2 reset_ni = 1'b0;
        model_reset();
        #1;
        check("t5_rst_req",  ctxtsw_req_o,  1'b0);
        check("t5_rst_tid",  thread_id_o,   0);
        check("t5_rst_ctx",  context_npc_o, BOOT);
        @(negedge clk);
        reset_ni = 1'b1;
        for (int k = 1; k < NT; k++) begin
            wait_req("t5_rot_timeout");
            check("t5_rot_next", next_thread_id_o, k);
            check("t5_rot_ctx",  context_npc_o,    BOOT);
            ctxtsw_yumi_i = 1'b1;
            tick();
            ctxtsw_yumi_i = 1'b0;
        end

        // quantum=0, no block: never switches.
        set_in(1, 16'd0, 4'hF, 0, 0);
        apply_reset();
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (ctxtsw_req_o) n++;
        end
        check("t4_no_req", n, 0);

        // Randomized run against the model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            en_i           = ($urandom_range(0, 7) != 0);
            quantum_i      = QW'($urandom_range(0, 6));
            thread_ready_i = NT'($urandom);
            block_i        = ($urandom_range(0, 3) == 0);
            ctxtsw_yumi_i  = ($urandom_range(0, 2) == 0);
            rnd            = {$urandom, $urandom};
            cur_npc_i      = rnd;
            npc_w_v_i      = ($urandom_range(0, 3) == 0);
            npc_w_tid_i    = 2'($urandom);
            rnd            = {$urandom, $urandom};
            npc_w_data_i   = rnd;
            tick(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
